rx_frame_parser: RTL and testbench

Sits directly downstream of the standardized UART receiver. It consumes the received byte stream (one-cycle data_valid pulses) and hunts for frame sync. It parses length, payload and checksum, buffering the payload internally. A payload is released on a valid/ready output stream only after its checksum passes; failed frames are discarded and flagged.

---
 rtl/rx_frame_parser.sv | 194 +++++++++++++++++++
 tb/tb_rx_frame_parser.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_parser.sv
// Purpose : hunts for SYNC_BYTE in a UART byte stream, parses LEN/payload/CHK,
//           buffers the payload and releases it only once the checksum matches.
// Latency : flags and out_valid appear one cycle after the accepting in_valid.
// Backpr. : out_valid/out_ready on the payload; none toward the UART, so a byte
//           arriving while the payload drains is dropped and flagged as overrun.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_data, in_valid     received byte and its one-cycle strobe
//   out_data, out_valid,  payload stream; out_last marks the final byte
//   out_ready, out_last
//   frame_done            one-cycle pulse: frame passed checksum
//   frame_err, err_code   one-cycle error pulse; code 0 chk, 1 len, 2 timeout, 3 overrun
//   busy                  high whenever the parser is not hunting for sync
module rx_frame_parser #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = 52080
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_done,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int IW = $clog2(MAX_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  // Buffer sized to the full index range so every index value is in bounds.
  localparam int DEPTH = 1 << IW;

  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TW-1:0] TO_LIMIT  = TW'(TIMEOUT_CLKS);

  localparam logic [1:0] ERR_CHK     = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

  typedef enum logic [2:0] {
    S_HUNT,
    S_LEN,
    S_PAYLOAD,
    S_CHECK,
    S_DRAIN
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   len_q, len_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   rd_idx_q, rd_idx_d;
  logic [7:0]      acc_q, acc_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [1:0]      code_q, code_d;

  logic [7:0]      mem [DEPTH];
  logic            wr_en;

  logic            in_frame;
  logic [TW-1:0]   tcnt_inc;
  logic            fire;

  // Drain outputs come straight from state and the buffer read port, so
  // they stay stable for as long as out_ready is held low.
  assign out_valid  = (state_q == S_DRAIN);
  assign out_data   = out_valid ? mem[rd_idx_q] : 8'h00;
  assign out_last   = out_valid && (rd_idx_q == len_q - IW'(1));
  assign busy       = (state_q != S_HUNT);
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign err_code   = code_q;

  assign fire     = out_valid && out_ready;
  assign in_frame = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHECK);
  assign tcnt_inc = tcnt_q + TW'(1);

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    rd_idx_d = rd_idx_q;
    acc_d    = acc_q;
    tcnt_d   = '0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    code_d   = code_q;
    wr_en    = 1'b0;

    // Silence inside a frame: count idle cycles; the cycle that would be the
    // TIMEOUT_CLKS-th silent one aborts. A byte on that cycle takes priority.
    if (in_frame && !in_valid) begin
      if (tcnt_inc == TO_LIMIT) begin
        err_d   = 1'b1;
        code_d  = ERR_TIMEOUT;
        state_d = S_HUNT;
      end else begin
        tcnt_d = tcnt_inc;
      end
    end

    case (state_q)
      S_HUNT: begin
        if (in_valid && in_data == SYNC_BYTE) state_d = S_LEN;
      end
      S_LEN: begin
        if (in_valid) begin
          // A repeated sync value lands here and is taken as a length.
          if (in_data == 8'h00 || in_data > MAX_LEN_B) begin
            err_d   = 1'b1;
            code_d  = ERR_LEN;
            state_d = S_HUNT;
          end else begin
            len_d   = in_data[IW-1:0];
            acc_d   = in_data;
            idx_d   = '0;
            state_d = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (in_valid) begin
          wr_en = 1'b1;
          acc_d = acc_q ^ in_data;
          idx_d = idx_q + IW'(1);
          if (idx_q == len_q - IW'(1)) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (in_valid) begin
          if (in_data == acc_q) begin
            done_d   = 1'b1;
            rd_idx_d = '0;
            state_d  = S_DRAIN;
          end else begin
            err_d   = 1'b1;
            code_d  = ERR_CHK;
            state_d = S_HUNT;
          end
        end
      end
      S_DRAIN: begin
        // Bytes arriving now are dropped, never hunted, even on the last beat.
        if (in_valid) begin
          err_d  = 1'b1;
          code_d = ERR_OVERRUN;
        end
        if (fire) begin
          rd_idx_d = rd_idx_q + IW'(1);
          if (out_last) state_d = S_HUNT;
        end
      end
      default: state_d = S_HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_HUNT;
      len_q    <= '0;
      idx_q    <= '0;
      rd_idx_q <= '0;
      acc_q    <= '0;
      tcnt_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= 2'd0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      rd_idx_q <= rd_idx_d;
      acc_q    <= acc_d;
      tcnt_q   <= tcnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      code_q   <= code_d;
    end
  end

  // Payload storage needs no reset; it is always written before it is read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[idx_q] <= in_data;
  end

endmodule

// File: tb/tb_rx_frame_parser.sv
// Directed bench for rx_frame_parser with a short inter-byte timeout.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Each scenario task drives its bytes and compares against hand-computed values.
module tb_rx_frame_parser;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       frame_done;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;

  int checks = 0;
  int errors = 0;

  rx_frame_parser #(
    .SYNC_BYTE   (8'hA5),
    .MAX_LEN     (16),
    .TIMEOUT_CLKS(100)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .frame_done(frame_done),
    .frame_err (frame_err),
    .err_code  (err_code),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle strobe; on return the sample point is the cycle after acceptance.
  task automatic send(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Strobe followed by two idle cycles (bytes spaced 3 cycles apart).
  task automatic sendg(input logic [7:0] b);
    send(b);
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    #2;
    checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (out_last !== 1'b0)   begin errors++; $display("FAIL rst_out_last: got %b want 0", out_last); end
    checks++; if (out_data !== 8'h00)  begin errors++; $display("FAIL rst_out_data: got %h want 00", out_data); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done: got %b want 0", frame_done); end
    checks++; if (frame_err !== 1'b0)  begin errors++; $display("FAIL rst_frame_err: got %b want 0", frame_err); end
    checks++; if (err_code !== 2'd0)   begin errors++; $display("FAIL rst_err_code: got %0d want 0", err_code); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_rst_busy: got %b want 0", busy); end
  endtask

  task automatic test_good_frame();
    out_ready = 1'b1;
    sendg(8'hA5);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL good_busy_after_sync: got %b want 1", busy); end
    sendg(8'h03); sendg(8'h11); sendg(8'h22); sendg(8'h33);
    send(8'h03);
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL good_done: got %b want 1", frame_done); end
    checks++; if (frame_err !== 1'b0)  begin errors++; $display("FAIL good_no_err: got %b want 0", frame_err); end
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h11 || out_last !== 1'b0)
      begin errors++; $display("FAIL good_beat0: got v=%b d=%h l=%b want v=1 d=11 l=0", out_valid, out_data, out_last); end
    tick();
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL good_done_pulse: got %b want 0", frame_done); end
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h22 || out_last !== 1'b0)
      begin errors++; $display("FAIL good_beat1: got v=%b d=%h l=%b want v=1 d=22 l=0", out_valid, out_data, out_last); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h33 || out_last !== 1'b1)
      begin errors++; $display("FAIL good_beat2: got v=%b d=%h l=%b want v=1 d=33 l=1", out_valid, out_data, out_last); end
    tick();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL good_end: got v=%b busy=%b want v=0 busy=0", out_valid, busy); end
    tick();
  endtask

  task automatic test_garbage_before_sync();
    sendg(8'h00); sendg(8'hFF); sendg(8'h5A);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL garbage_busy: got %b want 0", busy); end
    sendg(8'hA5); sendg(8'h01); sendg(8'h7E);
    send(8'h7F);
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL garbage_done: got %b want 1", frame_done); end
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h7E || out_last !== 1'b1)
      begin errors++; $display("FAIL garbage_beat: got v=%b d=%h l=%b want v=1 d=7e l=1", out_valid, out_data, out_last); end
    tick();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL garbage_end: got v=%b busy=%b want v=0 busy=0", out_valid, busy); end
    tick();
  endtask

  task automatic test_bad_checksum();
    int seen_valid;
    sendg(8'hA5); sendg(8'h03); sendg(8'h11); sendg(8'h22); sendg(8'h33);
    send(8'h04);
    checks++; if (frame_err !== 1'b1 || err_code !== 2'd0)
      begin errors++; $display("FAIL badchk_err: got err=%b code=%0d want err=1 code=0", frame_err, err_code); end
    checks++; if (frame_done !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL badchk_state: got done=%b busy=%b want 0 0", frame_done, busy); end
    seen_valid = 0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid === 1'b1) seen_valid++;
      tick();
    end
    checks++; if (seen_valid !== 0) begin errors++; $display("FAIL badchk_no_output: got %0d valid cycles want 0", seen_valid); end
    test_good_frame();
  endtask

  task automatic test_bad_length();
    sendg(8'hA5);
    send(8'h00);
    checks++; if (frame_err !== 1'b1 || err_code !== 2'd1)
      begin errors++; $display("FAIL badlen_zero: got err=%b code=%0d want err=1 code=1", frame_err, err_code); end
    tick(); tick();
    // Clear the held code with a checksum error so the next length error is visible.
    sendg(8'hA5); sendg(8'h01); sendg(8'h10);
    send(8'h00);
    checks++; if (err_code !== 2'd0) begin errors++; $display("FAIL badlen_setup_code: got %0d want 0", err_code); end
    tick(); tick();
    sendg(8'hA5);
    send(8'h11);
    checks++; if (frame_err !== 1'b1 || err_code !== 2'd1 || busy !== 1'b0)
      begin errors++; $display("FAIL badlen_17: got err=%b code=%0d busy=%b want 1 1 0", frame_err, err_code, busy); end
    tick(); tick();
    // MAX_LEN itself is legal: 16 bytes of 0x01, checksum 0x10.
    sendg(8'hA5); sendg(8'h10);
    checks++; if (frame_err !== 1'b0 && busy !== 1'b1) begin errors++; $display("FAIL badlen_max_rejected: got err=%b busy=%b want 0 1", frame_err, busy); end
    for (int i = 0; i < 16; i++) sendg(8'h01);
    send(8'h10);
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL badlen_max_done: got %b want 1", frame_done); end
    repeat (18) tick();
    sendg(8'hA5); sendg(8'h01); sendg(8'h7E);
    send(8'h7F);
    checks++; if (frame_done !== 1'b1 || out_data !== 8'h7E)
      begin errors++; $display("FAIL badlen_rehunt: got done=%b d=%h want 1 7e", frame_done, out_data); end
    tick(); tick();
  endtask

  task automatic test_timeout();
    sendg(8'hA5); sendg(8'h02);
    send(8'h11);
    repeat (99) tick();
    checks++; if (frame_err !== 1'b0 || busy !== 1'b1)
      begin errors++; $display("FAIL timeout_early: got err=%b busy=%b at cycle 100 want 0 1", frame_err, busy); end
    tick();
    checks++; if (frame_err !== 1'b1 || err_code !== 2'd2 || busy !== 1'b0)
      begin errors++; $display("FAIL timeout_fire: got err=%b code=%0d busy=%b at cycle 101 want 1 2 0", frame_err, err_code, busy); end
    tick();
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL timeout_pulse: got %b want 0", frame_err); end
    // Byte on the expiry cycle wins.
    sendg(8'hA5); sendg(8'h02);
    send(8'h11);
    repeat (99) tick();
    send(8'h22);
    checks++; if (frame_err !== 1'b0 || busy !== 1'b1)
      begin errors++; $display("FAIL timeout_race: got err=%b busy=%b want 0 1", frame_err, busy); end
    tick(); tick();
    send(8'h31);
    checks++; if (frame_done !== 1'b1 || out_data !== 8'h11)
      begin errors++; $display("FAIL timeout_race_done: got done=%b d=%h want 1 11", frame_done, out_data); end
    tick(); tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_race_end: got busy=%b want 0", busy); end
  endtask

  task automatic test_backpressure_overrun();
    int held_bad;
    out_ready = 1'b0;
    sendg(8'hA5); sendg(8'h03); sendg(8'h11); sendg(8'h22); sendg(8'h33);
    send(8'h03);
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL bp_done: got %b want 1", frame_done); end
    held_bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || out_data !== 8'h11 || out_last !== 1'b0) held_bad++;
      tick();
    end
    checks++; if (held_bad !== 0) begin errors++; $display("FAIL bp_hold: got %0d unstable cycles want 0", held_bad); end
    send(8'hA5);
    checks++; if (frame_err !== 1'b1 || err_code !== 2'd3)
      begin errors++; $display("FAIL bp_overrun: got err=%b code=%0d want err=1 code=3", frame_err, err_code); end
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h11)
      begin errors++; $display("FAIL bp_after_overrun: got v=%b d=%h want v=1 d=11", out_valid, out_data); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h22 || out_last !== 1'b0)
      begin errors++; $display("FAIL bp_beat1: got v=%b d=%h l=%b want 1 22 0", out_valid, out_data, out_last); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h33 || out_last !== 1'b1)
      begin errors++; $display("FAIL bp_beat2: got v=%b d=%h l=%b want 1 33 1", out_valid, out_data, out_last); end
    tick();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL bp_end: got v=%b busy=%b want 0 0", out_valid, busy); end
    // A dropped A5 must not have started a frame: a zero here is not a bad length.
    send(8'h00);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL bp_not_hunted: got err=%b want 0", frame_err); end
    tick(); tick();
  endtask

  task automatic test_last_with_overrun();
    out_ready = 1'b1;
    sendg(8'hA5); sendg(8'h01); sendg(8'h7E);
    send(8'h7F);
    send(8'hA5);
    checks++; if (frame_err !== 1'b1 || err_code !== 2'd3 || busy !== 1'b0 || out_valid !== 1'b0)
      begin errors++; $display("FAIL last_overrun: got err=%b code=%0d busy=%b v=%b want 1 3 0 0", frame_err, err_code, busy, out_valid); end
    send(8'h00);
    checks++; if (frame_err !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL last_overrun_not_hunted: got err=%b busy=%b want 0 0", frame_err, busy); end
    tick(); tick();
  endtask

  task automatic test_reset_midframe();
    sendg(8'hA5); sendg(8'h03); sendg(8'h11);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || frame_err !== 1'b0 || frame_done !== 1'b0)
      begin errors++; $display("FAIL midrst: got busy=%b err=%b done=%b want 0 0 0", busy, frame_err, frame_done); end
    tick();
    rst_n = 1'b1;
    tick();
    sendg(8'hA5); sendg(8'h01); sendg(8'h7E);
    send(8'h7F);
    checks++; if (frame_done !== 1'b1 || out_data !== 8'h7E || out_last !== 1'b1)
      begin errors++; $display("FAIL midrst_recover: got done=%b d=%h l=%b want 1 7e 1", frame_done, out_data, out_last); end
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_garbage_before_sync();
    test_bad_checksum();
    test_bad_length();
    test_timeout();
    test_backpressure_overrun();
    test_last_with_overrun();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
